inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/fetch_pkg.sv | 15 +
 rtl/inst_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch controller.
package fetch_pkg;

  localparam int unsigned BYTES_PER_INST = 4;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_INST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetches 32-bit little-endian instructions one byte per cycle from a byte-wide
// instruction memory and presents them with a valid/ready handshake.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic [31:0] fetch_count
);

  localparam int unsigned ADDR_W = 32;

  state_t            state, state_n;
  idx_t              b, b_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] next_pc_c;
  logic [ADDR_W-1:0] redirect_tgt_c;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       instr_n, instr_pc_n, fetch_count_n;
  logic              instr_valid_n, busy_n, accept_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and datapath next values; redirect overrides every state
  always_comb begin
    state_n       = state;
    b_n           = b;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    fetch_count_n = fetch_count;

    next_pc_c = (pc + ADDR_W'(BYTES_PER_INST) < ADDR_W'(MEM_BYTES))
                ? pc + ADDR_W'(BYTES_PER_INST) : '0;
    redirect_tgt_c = (redirect_pc & ~ADDR_W'(3)) % ADDR_W'(MEM_BYTES);
    accept_c       = (state == VALID) && instr_valid && instr_ready;

    case (state)
      IDLE: begin
        if (enable) begin
          state_n = FETCH;
          b_n     = '0;
        end
      end
      FETCH: begin
        instr_n[{b, 3'b000} +: 8] = mem_rdata;
        b_n = b + idx_t'(1);
        if (b == idx_t'(BYTES_PER_INST - 1)) begin
          state_n       = VALID;
          instr_valid_n = 1'b1;
          instr_pc_n    = pc;
        end
      end
      VALID: begin
        if (accept_c) begin
          fetch_count_n = fetch_count + 32'd1;
          pc_n          = next_pc_c;
          instr_valid_n = 1'b0;
          b_n           = '0;
          state_n       = enable ? FETCH : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (redirect_valid) begin
      pc_n          = redirect_tgt_c;
      b_n           = '0;
      instr_valid_n = 1'b0;
      state_n       = enable ? FETCH : IDLE;
    end

    // Address is registered, so it is computed from the values the next cycle will hold
    mem_addr_n = (state_n == FETCH) ? pc_n + ADDR_W'(b_n) : pc_n;
    busy_n     = (state_n == FETCH);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      b           <= '0;
      pc          <= RESET_PC;
      mem_addr    <= RESET_PC;
      instr       <= '0;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      fetch_count <= '0;
    end else begin
      b           <= b_n;
      pc          <= pc_n;
      mem_addr    <= mem_addr_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      busy        <= busy_n;
      fetch_count <= fetch_count_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed, table-driven bench for inst_fetch_ctrl with a 32-byte memory model.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic [31:0] fetch_count;

  logic [7:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[4:0]];

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_BYTES(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .busy           (busy),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        en;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        valid;
    logic        bsy;
    logic [31:0] cnt;
    logic        chk_instr;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[40];

  function automatic vec_t mk(logic en, logic rdy, logic rv, logic [31:0] rpc,
                              logic [31:0] addr, logic valid, logic bsy, logic [31:0] cnt,
                              logic chk, logic [31:0] ins, logic [31:0] ipc);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.addr = addr; v.valid = valid; v.bsy = bsy; v.cnt = cnt;
    v.chk_instr = chk; v.ins = ins; v.ipc = ipc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " mem_addr"},    mem_addr, 32'h0);
    check({tag, " instr"},       instr, 32'h0);
    check({tag, " instr_pc"},    instr_pc, 32'h0);
    check({tag, " instr_valid"}, 32'(instr_valid), 32'h0);
    check({tag, " busy"},        32'(busy), 32'h0);
    check({tag, " fetch_count"}, fetch_count, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cycles;

    mem[0] = 8'h33; mem[1] = 8'h03; mem[2] = 8'h94; mem[3] = 8'h00;
    for (int i = 4; i < 32; i++) mem[i] = 8'(i);

    // en rdy rv rpc | addr valid busy cnt | chk instr ipc
    vecs[0]  = mk(1, 1, 0, 0,     0,  0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0,     1,  0, 1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0,     2,  0, 1, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0,     3,  0, 1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 0,     0,  1, 0, 0, 1, 32'h0094_0333, 0);
    vecs[5]  = mk(1, 0, 0, 0,     0,  1, 0, 0, 1, 32'h0094_0333, 0);
    vecs[6]  = mk(1, 0, 0, 0,     0,  1, 0, 0, 1, 32'h0094_0333, 0);
    vecs[7]  = mk(1, 0, 0, 0,     0,  1, 0, 0, 1, 32'h0094_0333, 0);
    vecs[8]  = mk(1, 1, 0, 0,     4,  0, 1, 1, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0,     5,  0, 1, 1, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 0,     6,  0, 1, 1, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 0,     7,  0, 1, 1, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, 0,     4,  1, 0, 1, 1, 32'h0706_0504, 4);
    vecs[13] = mk(1, 0, 1, 28,    28, 0, 1, 1, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0,     29, 0, 1, 1, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 0,     30, 0, 1, 1, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 0,     31, 0, 1, 1, 0, 0, 0);
    vecs[17] = mk(1, 0, 0, 0,     28, 1, 0, 1, 1, 32'h1f1e_1d1c, 28);
    vecs[18] = mk(1, 1, 0, 0,     0,  0, 1, 2, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 0,     1,  0, 1, 2, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 0,     2,  0, 1, 2, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0,     3,  0, 1, 2, 0, 0, 0);
    vecs[22] = mk(1, 0, 0, 0,     0,  1, 0, 2, 1, 32'h0094_0333, 0);
    vecs[23] = mk(1, 1, 1, 32'h10, 16, 0, 1, 3, 0, 0, 0);
    vecs[24] = mk(1, 0, 1, 32'h47, 4,  0, 1, 3, 0, 0, 0);
    vecs[25] = mk(1, 0, 0, 0,     5,  0, 1, 3, 0, 0, 0);
    vecs[26] = mk(0, 0, 0, 0,     6,  0, 1, 3, 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 0,     7,  0, 1, 3, 0, 0, 0);
    vecs[28] = mk(0, 0, 0, 0,     4,  1, 0, 3, 1, 32'h0706_0504, 4);
    vecs[29] = mk(0, 1, 0, 0,     8,  0, 0, 4, 0, 0, 0);
    vecs[30] = mk(0, 0, 0, 0,     8,  0, 0, 4, 0, 0, 0);
    vecs[31] = mk(0, 0, 1, 32'h0E, 12, 0, 0, 4, 0, 0, 0);
    vecs[32] = mk(1, 0, 1, 4,     4,  0, 1, 4, 0, 0, 0);
    vecs[33] = mk(1, 0, 0, 0,     5,  0, 1, 4, 0, 0, 0);
    vecs[34] = mk(1, 0, 0, 0,     6,  0, 1, 4, 0, 0, 0);
    vecs[35] = mk(1, 0, 1, 32'h0E, 12, 0, 1, 4, 0, 0, 0);
    vecs[36] = mk(1, 0, 0, 0,     13, 0, 1, 4, 0, 0, 0);
    vecs[37] = mk(1, 0, 0, 0,     14, 0, 1, 4, 0, 0, 0);
    vecs[38] = mk(1, 0, 0, 0,     15, 0, 1, 4, 0, 0, 0);
    vecs[39] = mk(1, 0, 0, 0,     12, 1, 0, 4, 1, 32'h0f0e_0d0c, 12);

    reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    step(); step();
    check_reset_values("reset");
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      enable         = vecs[i].en;
      instr_ready    = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      step();
      check($sformatf("v%0d mem_addr", i),    mem_addr, vecs[i].addr);
      check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d busy", i),        32'(busy), 32'(vecs[i].bsy));
      check($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].cnt);
      if (vecs[i].chk_instr) begin
        check($sformatf("v%0d instr", i),    instr, vecs[i].ins);
        check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].ipc);
      end
    end
    redirect_valid = 1'b0;

    // Accept pc=12, then reset in the middle of the next fetch
    enable = 1'b1; instr_ready = 1'b1;
    step();
    check("pre-reset count", fetch_count, 32'd5);
    check("pre-reset addr",  mem_addr, 32'd16);
    instr_ready = 1'b0;
    step();
    check("pre-reset b1 addr", mem_addr, 32'd17);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8; instr_ready = 1'b1;
    step();
    check_reset_values("midfetch reset");
    reset = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    step();
    check("restart addr", mem_addr, 32'd0);
    check("restart busy", 32'(busy), 32'd1);
    cycles = 0;
    while (!instr_valid && cycles < 10) begin
      step();
      cycles++;
    end
    check("restart latency", 32'(cycles), 32'd4);
    check("restart instr",    instr, 32'h0094_0333);
    check("restart instr_pc", instr_pc, 32'd0);
    check("restart count",    fetch_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
